// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin arbitrated front end for one shared bit-serial adder.
// Two requesters hand over WIDTH-bit operand pairs; the winner's operands are
// shifted LSB-first through a one-bit full adder with a carry flop, and the
// parallel result comes back with a one-cycle done pulse tagged by owner.
// Optional feature macro: SERIAL_SUB_EN (adds sub0/sub1 for a - b).
//
// state   | meaning
// S_IDLE  | waiting for a request, arbitrate on each edge
// S_SHIFT | WIDTH cycles, one sum bit per cycle
// S_DONE  | one cycle, done high with sum/cout valid
module serial_add_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
`ifdef SERIAL_SUB_EN
    input  logic             sub0,
    input  logic             sub1,
`endif
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done,
    output logic             owner,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             last_grant;

    logic             win;
    logic             sub_win;
    logic [WIDTH-1:0] b_win;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] acc_next;

    // Arbitration: a lone request wins; on a tie the one not served last wins.
    always_comb begin
        win = (req0 && req1) ? ~last_grant : req1;
`ifdef SERIAL_SUB_EN
        sub_win = win ? sub1 : sub0;
`else
        sub_win = 1'b0;
`endif
        b_win = win ? b1 : b0;
        if (sub_win) begin
            b_win = ~b_win;
        end
    end

    // One-bit full adder and the next value of the internal sum shifter.
    always_comb begin
        s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
        c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        acc_next = acc >> 1;
        acc_next[WIDTH-1] = s_bit;
    end

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
            done       <= 1'b0;
            owner      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        a_sh       <= win ? a1 : a0;
                        b_sh       <= b_win;
                        carry      <= sub_win;
                        cnt        <= '0;
                        owner      <= win;
                        last_grant <= win;
                        ack0       <= ~win;
                        ack1       <= win;
                        busy       <= 1'b1;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Publish only the finished word so sum holds between results.
                        sum   <= acc_next;
                        cout  <= c_next;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched (WIDTH=4); sub tests build with SERIAL_SUB_EN.
module tb_serial_add_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
`ifdef SERIAL_SUB_EN
    logic       sub0 = 1'b0, sub1 = 1'b0;
`endif
    logic       ack0, ack1, cout, done, owner, busy;
    logic [3:0] sum;

    int total = 0;
    int passed = 0;

    serial_add_sched #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
`ifdef SERIAL_SUB_EN
        .sub0(sub0), .sub1(sub1),
`endif
        .ack0(ack0), .ack1(ack1), .sum(sum), .cout(cout),
        .done(done), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks until done is seen (bounded); reports how many edges it took.
    task automatic wait_done(output int n, output logic seen);
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum"}, 32'(sum), 0);
        check({tag, "_cout"}, 32'(cout), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ack0"}, 32'(ack0), 0);
        check({tag, "_ack1"}, 32'(ack1), 0);
        check({tag, "_owner"}, 32'(owner), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int   n;
        logic seen;
        int   busy_cnt;
        int   done_cnt;
        int   ack1_cnt;
        int   last_t;
        int   own_exp;
        int   sum_exp;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check_zero("rst");

        // req0: 5 + 3 = 8
        req0 = 1'b1; a0 = 4'b0101; b0 = 4'b0011;
        tick();                                   // E0
        req0 = 1'b0;
        check("t1_ack0", 32'(ack0), 1);
        check("t1_ack1", 32'(ack1), 0);
        check("t1_busy", 32'(busy), 1);
        tick();                                   // E1
        check("t1_ack0_fall", 32'(ack0), 0);
        tick(); tick();                           // E3
        check("t1_done_early", 32'(done), 0);
        tick();                                   // E4: done visible until E5
        check("t1_done", 32'(done), 1);
        check("t1_sum", 32'(sum), 32'h8);
        check("t1_cout", 32'(cout), 0);
        check("t1_owner", 32'(owner), 0);
        tick();                                   // E5
        check("t1_done_fall", 32'(done), 0);
        check("t1_sum_hold", 32'(sum), 32'h8);
        check("t1_busy_fall", 32'(busy), 0);

        // req1: F + 1 = 0 carry 1; busy spans E0 through the DONE cycle = 5 cycles
        req1 = 1'b1; a1 = 4'hF; b1 = 4'h1;
        busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            req1 = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1 && !seen) begin
                seen = 1'b1;
                check("t2_sum", 32'(sum), 32'h0);
                check("t2_cout", 32'(cout), 1);
                check("t2_owner", 32'(owner), 1);
            end
        end
        check("t2_done_seen", 32'(seen), 1);
        check("t2_busy_cycles", 32'(busy_cnt), 5);

        // Both requests held from reset: grants alternate 0,1,0,1 every 6 cycles
        reset = 1'b1;
        req0 = 1'b1; a0 = 4'h5; b0 = 4'h3;
        req1 = 1'b1; a1 = 4'h9; b1 = 4'h4;
        tick();
        reset = 1'b0;
        done_cnt = 0; last_t = 0;
        for (int t = 0; t < 40 && done_cnt < 4; t++) begin
            tick();
            if (done === 1'b1) begin
                own_exp = done_cnt % 2;
                sum_exp = (own_exp == 0) ? 32'h8 : 32'hD;
                check("t3_owner", 32'(owner), 32'(own_exp));
                check("t3_sum", 32'(sum), 32'(sum_exp));
                if (done_cnt > 0) check("t3_spacing", 32'(t - last_t), 6);
                last_t = t;
                done_cnt++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("t3_done_count", 32'(done_cnt), 4);
        tick(); tick();
        check("t3_idle", 32'(busy), 0);

        // Reset during the third SHIFT cycle
        req0 = 1'b1; a0 = 4'h5; b0 = 4'h3;
        tick();                                   // E0
        req0 = 1'b0;
        tick(); tick();                           // now in E2..E3, third SHIFT cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("t4_rst");
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        check("t4_no_done", 32'(done_cnt), 0);
        req0 = 1'b1; a0 = 4'h7; b0 = 4'h8;
        tick();
        req0 = 1'b0;
        wait_done(n, seen);
        check("t4_done_seen", 32'(seen), 1);
        check("t4_latency", 32'(n), 4);
        check("t4_sum", 32'(sum), 32'hF);
        check("t4_cout", 32'(cout), 0);
        tick(); tick();

        // req1 pulsed only during SHIFT is ignored
        req0 = 1'b1; a0 = 4'h1; b0 = 4'h1;
        tick();                                   // E0
        req0 = 1'b0;
        tick();                                   // E1
        req1 = 1'b1; a1 = 4'h3; b1 = 4'h3;
        tick();                                   // E2
        req1 = 1'b0;
        done_cnt = 0; ack1_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                check("t5_sum", 32'(sum), 32'h2);
            end
            if (ack1 === 1'b1) ack1_cnt++;
        end
        check("t5_done_count", 32'(done_cnt), 1);
        check("t5_no_ack1", 32'(ack1_cnt), 0);

`ifdef SERIAL_SUB_EN
        // 3 - 5 = E with borrow
        req1 = 1'b1; sub1 = 1'b1; a1 = 4'h3; b1 = 4'h5;
        tick();
        req1 = 1'b0;
        wait_done(n, seen);
        check("s1_done_seen", 32'(seen), 1);
        check("s1_sum", 32'(sum), 32'hE);
        check("s1_cout", 32'(cout), 0);
        check("s1_owner", 32'(owner), 1);
        tick(); tick();
        // 5 - 3 = 2, no borrow
        req0 = 1'b1; sub0 = 1'b1; a0 = 4'h5; b0 = 4'h3;
        tick();
        req0 = 1'b0;
        wait_done(n, seen);
        check("s2_done_seen", 32'(seen), 1);
        check("s2_sum", 32'(sum), 32'h2);
        check("s2_cout", 32'(cout), 1);
        tick(); tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
